// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   INST_W / OFF_W       instruction word width, branch offset width
//   BS_*                 branch-select encodings driven by the decoder
//   state_t              fetch FSM states
package fetch_pkg;

  localparam int INST_W = 16;
  localparam int OFF_W  = 6;
  localparam int BS_W   = 3;

  localparam logic [BS_W-1:0] BS_BEQ  = 3'b000;  // taken when Z
  localparam logic [BS_W-1:0] BS_BNE  = 3'b001;  // taken when !Z
  localparam logic [BS_W-1:0] BS_BN   = 3'b010;  // taken when N
  localparam logic [BS_W-1:0] BS_BNN  = 3'b011;  // taken when !N
  localparam logic [BS_W-1:0] BS_NONE = 3'b100;  // 1xx: never taken

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_unit_branch.sv
// branch_unit: combinational branch resolution for the fetch stage.
//   bs      in   3     branch select (see fetch_pkg BS_*)
//   z, n    in   1     ALU zero / negative flags
//   br_pc   in   PC_W  PC of the resolving branch
//   off     in   6     signed word offset
//   taken   out  1     branch condition holds
//   target  out  PC_W  br_pc + 1 + sext(off), wrapping modulo 2^PC_W
module branch_unit import fetch_pkg::*; #(
  parameter int PC_W = 8
) (
  input  logic [BS_W-1:0]  bs,
  input  logic             z,
  input  logic             n,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] off,
  output logic             taken,
  output logic [PC_W-1:0]  target
);

  logic [PC_W-1:0] off_ext;

  // Width cast of a signed operand sign-extends the offset to PC width.
  assign off_ext = PC_W'(signed'(off));
  assign target  = br_pc + PC_W'(1) + off_ext;

  always_comb begin
    taken = 1'b0;
    if (bs < BS_NONE) begin
      unique case (bs)
        BS_BEQ:  taken = z;
        BS_BNE:  taken = ~z;
        BS_BN:   taken = n;
        BS_BNN:  taken = ~n;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the decoder.
//   CLK, RST                 clock (rising), async active-high reset
//   IMEM_REQ/ADDR/ACK/RDATA  word-read handshake to instruction memory;
//                            REQ held with ADDR stable until ACK
//   INST/INST_PC/INST_VALID  instruction register and its fetch address
//   STALL                    decoder not ready; INST consumed on VALID & !STALL
//   HLT                      current INST is a halt; stops fetch on consume
//   BR_VALID/BR_PC/BS/OFF/Z/N branch resolution from downstream
//   BR_TAKEN                 one-cycle pulse after a redirect is applied
//   HALTED                   core halted until reset
module fetch_unit import fetch_pkg::*; #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMEM_REQ,
  output logic [PC_W-1:0]   IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [INST_W-1:0] IMEM_RDATA,
  output logic [INST_W-1:0] INST,
  output logic [PC_W-1:0]   INST_PC,
  output logic              INST_VALID,
  input  logic              STALL,
  input  logic              HLT,
  input  logic              BR_VALID,
  input  logic [PC_W-1:0]   BR_PC,
  input  logic [BS_W-1:0]   BS,
  input  logic [OFF_W-1:0]  OFF,
  input  logic              Z,
  input  logic              N,
  output logic              BR_TAKEN,
  output logic              HALTED
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              discard_q, discard_d;
  logic              req_q, req_d;
  logic              br_taken_q, br_taken_d;
  logic              halted_q, halted_d;

  logic              br_taken_raw;
  logic [PC_W-1:0]   br_target;
  logic              redirect;
  logic              consume;

  branch_unit #(.PC_W(PC_W)) u_branch (
    .bs     (BS),
    .z      (Z),
    .n      (N),
    .br_pc  (BR_PC),
    .off    (OFF),
    .taken  (br_taken_raw),
    .target (br_target)
  );

  assign redirect = BR_VALID & br_taken_raw & (state_q != ST_HALTED);
  assign consume  = (state_q == ST_HOLD) & inst_valid_q & ~STALL;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    discard_d    = discard_q;
    halted_d     = halted_q;
    br_taken_d   = redirect;

    if (redirect) begin
      pc_d         = br_target;
      inst_valid_d = 1'b0;
      state_d      = ST_REQ;
      // A request still in flight must finish at its old address; its data
      // is then thrown away. If it completes this very cycle it is dropped
      // here and nothing is left to discard.
      discard_d    = (state_q == ST_REQ) & ~IMEM_ACK;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (IMEM_ACK) begin
            if (discard_q) begin
              // Wrong-path data: drop it and re-request at the redirected PC.
              discard_d = 1'b0;
            end else begin
              inst_d       = IMEM_RDATA;
              inst_pc_d    = addr_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + PC_W'(1);
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (consume) begin
            inst_valid_d = 1'b0;
            if (HLT) begin
              state_d  = ST_HALTED;
              halted_d = 1'b1;
            end else begin
              state_d  = ST_REQ;
            end
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end

    // The address only moves when no request is outstanding, so it stays
    // stable for the full REQ..ACK window even across a redirect.
    addr_d = ((state_q == ST_REQ) && !IMEM_ACK) ? addr_q : pc_d;
    req_d  = (state_d == ST_REQ);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      req_q        <= 1'b0;
      br_taken_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      discard_q    <= discard_d;
      req_q        <= req_d;
      br_taken_q   <= br_taken_d;
      halted_q     <= halted_d;
    end
  end

  assign IMEM_REQ   = req_q;
  assign IMEM_ADDR  = addr_q;
  assign INST       = inst_q;
  assign INST_PC    = inst_pc_q;
  assign INST_VALID = inst_valid_q;
  assign BR_TAKEN   = br_taken_q;
  assign HALTED     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder acks only as many
// requests as the stimulus grants; a monitor checks every completed memory
// request address and every consumed instruction against expected queues.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IMEM_REQ;
  logic [7:0]  IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [15:0] IMEM_RDATA = 16'h0;
  logic [15:0] INST;
  logic [7:0]  INST_PC;
  logic        INST_VALID;
  logic        STALL = 1'b0;
  logic        HLT = 1'b0;
  logic        BR_VALID = 1'b0;
  logic [7:0]  BR_PC = 8'h0;
  logic [2:0]  BS = 3'b100;
  logic [5:0]  OFF = 6'h0;
  logic        Z = 1'b0;
  logic        N = 1'b0;
  logic        BR_TAKEN;
  logic        HALTED;

  fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID),
    .STALL(STALL), .HLT(HLT),
    .BR_VALID(BR_VALID), .BR_PC(BR_PC), .BS(BS), .OFF(OFF), .Z(Z), .N(N),
    .BR_TAKEN(BR_TAKEN), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [0:255];
  int grants = 0;      // written by stimulus only
  int acks_given = 0;  // written by responder only
  int lat = 2;
  int cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic [7:0]  exp_addr_q [$];
  logic [23:0] exp_inst_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Memory responder: ack after 'lat' cycles of REQ, if a grant is available.
  always @(posedge CLK) begin
    #2;
    if (IMEM_ACK) begin
      IMEM_ACK = 1'b0;
      cnt = 0;
    end
    if (!IMEM_REQ || RST) cnt = 0;
    else begin
      cnt++;
      if (cnt >= lat && acks_given < grants) begin
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = mem[IMEM_ADDR];
        acks_given++;
      end
    end
  end

  // Monitor: compare completed requests and consumed instructions.
  always @(negedge CLK) begin
    if (!RST) begin
      if (IMEM_REQ && IMEM_ACK) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL imem_addr: got unexpected request %h, required none", IMEM_ADDR);
        end else check("imem_addr", 32'(IMEM_ADDR), 32'(exp_addr_q.pop_front()));
      end
      if (INST_VALID && !STALL) begin
        if (exp_inst_q.size() == 0) begin
          n_checks++;
          $display("FAIL inst: got unexpected consume %h@%h, required none", INST, INST_PC);
        end else check("inst", 32'({INST, INST_PC}), 32'(exp_inst_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    @(negedge CLK);
    while (!INST_VALID && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 50) begin
      n_checks++;
      $display("FAIL %s: got timeout waiting INST_VALID, required valid", nm);
    end
    step();
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_addr_q.size() != 0 || exp_inst_q.size() != 0) && k < 100) begin
      step();
      k++;
    end
    if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: got %0d addr / %0d inst pending, required 0", nm,
               exp_addr_q.size(), exp_inst_q.size());
      exp_addr_q.delete();
      exp_inst_q.delete();
    end
  endtask

  task automatic pulse_br(input logic [2:0] bs_i, input logic z_i, input logic n_i,
                          input logic [7:0] pc_i, input logic [5:0] off_i);
    BR_VALID = 1'b1; BS = bs_i; Z = z_i; N = n_i; BR_PC = pc_i; OFF = off_i;
    step();
    BR_VALID = 1'b0; BS = 3'b100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'hF0C8;

    // Reset state
    step(); step();
    at_neg();
    check("rst_req", 32'(IMEM_REQ), 32'd0);
    check("rst_addr", 32'(IMEM_ADDR), 32'd0);
    check("rst_inst", 32'(INST), 32'd0);
    check("rst_inst_pc", 32'(INST_PC), 32'd0);
    check("rst_valid", 32'(INST_VALID), 32'd0);
    check("rst_br_taken", 32'(BR_TAKEN), 32'd0);
    check("rst_halted", 32'(HALTED), 32'd0);

    // 1: two sequential fetches, consumed immediately
    exp_addr_q.push_back(8'h00); exp_addr_q.push_back(8'h01);
    exp_inst_q.push_back({16'hF0C8, 8'h00}); exp_inst_q.push_back({16'h1001, 8'h01});
    grants = grants + 2;
    step();
    RST = 1'b0;
    drain("t1_drain");
    at_neg();
    check("t1_valid_pulse", 32'(INST_VALID), 32'd0);
    check("t1_next_req", 32'(IMEM_REQ), 32'd1);
    check("t1_next_addr", 32'(IMEM_ADDR), 32'd2);

    // 2: stall holds the IR and blocks further requests
    step();
    STALL = 1'b1;
    exp_addr_q.push_back(8'h02);
    exp_inst_q.push_back({16'h1002, 8'h02});
    grants = grants + 1;
    wait_valid("t2_wait");
    for (int c = 0; c < 3; c++) begin
      at_neg();
      check("t2_inst_held", 32'(INST), 32'h1002);
      check("t2_valid_held", 32'(INST_VALID), 32'd1);
      check("t2_no_req", 32'(IMEM_REQ), 32'd0);
      step();
    end
    STALL = 1'b0;
    drain("t2_drain");

    // 3: taken BEQ from HOLD, then a BS=1xx no-op
    STALL = 1'b1;
    exp_addr_q.push_back(8'h03);
    grants = grants + 1;
    wait_valid("t3_wait");
    at_neg();
    check("t3_inst", 32'({INST, INST_PC}), 32'({16'h1003, 8'h03}));
    step();
    pulse_br(3'b000, 1'b1, 1'b0, 8'h05, 6'h3E);
    at_neg();
    check("t3_br_taken", 32'(BR_TAKEN), 32'd1);
    check("t3_flush", 32'(INST_VALID), 32'd0);
    check("t3_req", 32'(IMEM_REQ), 32'd1);
    check("t3_target", 32'(IMEM_ADDR), 32'h04);
    step();
    at_neg();
    check("t3_br_taken_pulse", 32'(BR_TAKEN), 32'd0);
    step();
    exp_addr_q.push_back(8'h04);
    exp_inst_q.push_back({16'h1004, 8'h04});
    grants = grants + 1;
    wait_valid("t3b_wait");
    pulse_br(3'b100, 1'b1, 1'b0, 8'h05, 6'h3E);
    at_neg();
    check("t3b_no_taken", 32'(BR_TAKEN), 32'd0);
    check("t3b_valid_kept", 32'(INST_VALID), 32'd1);
    check("t3b_inst_kept", 32'(INST), 32'h1004);
    step();
    STALL = 1'b0;
    drain("t3b_drain");

    // 4: redirect while request to 05 is outstanding; its data is dropped
    mem[5] = 16'h5041;
    pulse_br(3'b001, 1'b0, 1'b0, 8'h0A, 6'h05);
    at_neg();
    check("t4_br_taken", 32'(BR_TAKEN), 32'd1);
    check("t4_req_held", 32'(IMEM_REQ), 32'd1);
    check("t4_addr_held", 32'(IMEM_ADDR), 32'h05);
    check("t4_valid0", 32'(INST_VALID), 32'd0);
    step();
    at_neg();
    check("t4_valid0_b", 32'(INST_VALID), 32'd0);
    step();
    exp_addr_q.push_back(8'h05); exp_addr_q.push_back(8'h10);
    exp_inst_q.push_back({16'h1010, 8'h10});
    grants = grants + 2;
    step();
    at_neg();
    check("t4_dropped", 32'(INST_VALID), 32'd0);
    check("t4_new_addr", 32'(IMEM_ADDR), 32'h10);
    check("t4_new_req", 32'(IMEM_REQ), 32'd1);
    step();
    drain("t4_drain");

    // 6: branch to FE, fetch through the PC wrap, then FE+1+5 -> 04
    pulse_br(3'b010, 1'b0, 1'b1, 8'hF0, 6'h0D);
    at_neg();
    check("t6_br_taken", 32'(BR_TAKEN), 32'd1);
    step();
    exp_addr_q.push_back(8'h11); exp_addr_q.push_back(8'hFE);
    exp_addr_q.push_back(8'hFF); exp_addr_q.push_back(8'h00);
    exp_inst_q.push_back({16'h10FE, 8'hFE});
    exp_inst_q.push_back({16'h10FF, 8'hFF});
    exp_inst_q.push_back({16'hF0C8, 8'h00});
    grants = grants + 4;
    drain("t6_wrap_drain");
    pulse_br(3'b011, 1'b0, 1'b0, 8'hFE, 6'h05);
    at_neg();
    check("t6b_br_taken", 32'(BR_TAKEN), 32'd1);
    step();
    exp_addr_q.push_back(8'h01); exp_addr_q.push_back(8'h04);
    exp_inst_q.push_back({16'h1004, 8'h04});
    grants = grants + 2;
    drain("t6b_drain");

    // 5: HLT instruction consumed -> halted until reset
    mem[5] = 16'h0001;
    STALL = 1'b1;
    exp_addr_q.push_back(8'h05);
    grants = grants + 1;
    wait_valid("t5_wait");
    exp_inst_q.push_back({16'h0001, 8'h05});
    HLT = 1'b1;
    STALL = 1'b0;
    step();
    HLT = 1'b0;
    at_neg();
    check("t5_halted", 32'(HALTED), 32'd1);
    check("t5_no_req", 32'(IMEM_REQ), 32'd0);
    check("t5_valid0", 32'(INST_VALID), 32'd0);
    step();
    grants = grants + 5;
    pulse_br(3'b000, 1'b1, 1'b0, 8'h05, 6'h3E);
    at_neg();
    check("t5_br_ignored", 32'(BR_TAKEN), 32'd0);
    for (int c = 0; c < 5; c++) begin
      at_neg();
      check("t5_stay_halted", 32'({HALTED, IMEM_REQ}), 32'b10);
      step();
    end
    #2 RST = 1'b1;
    #1;
    check("t5_rst_halted", 32'(HALTED), 32'd0);
    check("t5_rst_inst", 32'(INST), 32'd0);
    grants = acks_given + 1;
    exp_addr_q.push_back(8'h00);
    exp_inst_q.push_back({16'hF0C8, 8'h00});
    step();
    RST = 1'b0;
    drain("t5_restart_drain");
    at_neg();
    check("t5_restart_req", 32'({IMEM_REQ, IMEM_ADDR}), 32'({1'b1, 8'h01}));

    // Async reset with a request outstanding
    #1 RST = 1'b1;
    #1;
    check("arst_req", 32'(IMEM_REQ), 32'd0);
    check("arst_inst", 32'(INST), 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
